// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a register-file memory: byte-lane writes,
// programmable wait states, two-cycle ERROR responses.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ph_vld;
  logic                  ph_wr;
  logic [ADDR_WIDTH-1:0] ph_addr;
  logic [2:0]            ph_size;
  logic [CW-1:0]         cnt;

  logic [ADDR_WIDTH-1:0] a_widx;
  logic [ADDR_WIDTH-1:0] p_widx;
  logic [31:0]           sz_bytes;
  logic [31:0]           p_lane;
  logic [31:0]           p_len;
  logic [NB-1:0]         be;
  logic                  accept;
  logic                  bad;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rword;
  logic                  unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign a_widx = HADDR >> LSB;
  assign p_widx = ph_addr >> LSB;

  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign commit = ph_vld & ph_wr & HREADYOUT;

  always_comb begin
    sz_bytes = 32'd1 << HSIZE;
    bad = (a_widx >= ADDR_WIDTH'(MEM_DEPTH))
       || (sz_bytes > 32'(NB))
       || ((HADDR & ADDR_WIDTH'(sz_bytes - 32'd1)) != '0);
  end

  always_comb begin
    p_lane = 32'(ph_addr) & 32'(NB - 1);
    p_len  = 32'd1 << ph_size;
    be     = '0;
    for (int b = 0; b < NB; b++) begin
      be[b] = (32'(b) >= p_lane) && (32'(b) < p_lane + p_len);
    end
  end

  // A write completing on the edge that accepts a read of the same
  // word must be visible to that read.
  always_comb begin
    rword = mem[a_widx[IW-1:0]];
    if (commit && (p_widx == a_widx)) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) rword[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      ph_vld    <= 1'b0;
      ph_wr     <= 1'b0;
      ph_addr   <= '0;
      ph_size   <= '0;
      cnt       <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (commit) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[p_widx[IW-1:0]][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
      unique case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          ph_vld    <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          if (accept && bad) begin
            state     <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (accept) begin
            ph_vld  <= 1'b1;
            ph_wr   <= HWRITE;
            ph_addr <= HADDR;
            ph_size <= HSIZE;
            if (!HWRITE) HRDATA <= rword;
            if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              HREADYOUT <= 1'b0;
              cnt       <= CW'(WAIT_STATES - 1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: zero-wait and three-wait instances share one bus,
// HSEL picks the target.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tgt = 1'b0;
  logic        hold_lo = 1'b0;
  logic        sel0, sel3, hwrite;
  logic [9:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] rd0, rd3;
  logic        ro0, rp0, ro3, rp3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign hready = hold_lo ? 1'b0 : (tgt ? ro3 : ro0);

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rp0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rp3)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adr(input logic [1:0] tr, input logic wr,
                     input logic [9:0] a, input logic [2:0] sz);
    sel0   = !tgt;
    sel3   = tgt;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic idle();
    sel0   = 1'b0;
    sel3   = 1'b0;
    htrans = T_IDLE;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = 3'd2;
  endtask

  initial begin
    idle();
    hwdata = '0;
    cyc();
    cyc();
    chk1("rst_ready0", ro0, 1'b1);
    chk1("rst_resp0", rp0, 1'b0);
    chk32("rst_rdata0", rd0, 32'h0);
    chk1("rst_ready3", ro3, 1'b1);
    rst = 1'b0;

    // word write then immediate read of the same word
    adr(T_NSEQ, 1'b1, 10'h004, 3'd2);
    cyc();
    hwdata = 32'hDEADBEEF;
    chk1("wr_nostall", ro0, 1'b1);
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    idle();
    chk1("rd_nostall", ro0, 1'b1);
    chk1("rd_okay", rp0, 1'b0);
    chk32("rd_fwd", rd0, 32'hDEADBEEF);
    cyc();

    // byte and halfword lane writes
    adr(T_NSEQ, 1'b1, 10'h004, 3'd2);
    cyc();
    hwdata = 32'h11223344;
    adr(T_NSEQ, 1'b1, 10'h005, 3'd0);
    cyc();
    hwdata = 32'hFFFFAAFF;
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    idle();
    chk32("byte_lane", rd0, 32'h1122AA44);
    adr(T_NSEQ, 1'b1, 10'h006, 3'd1);
    cyc();
    hwdata = 32'h55661234;
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    idle();
    chk32("half_lane", rd0, 32'h5566AA44);
    cyc();

    // out-of-range read
    adr(T_NSEQ, 1'b0, 10'h100, 3'd2);
    cyc();
    idle();
    chk1("oor_e1_ready", ro0, 1'b0);
    chk1("oor_e1_resp", rp0, 1'b1);
    cyc();
    chk1("oor_e2_ready", ro0, 1'b1);
    chk1("oor_e2_resp", rp0, 1'b1);
    cyc();
    chk1("oor_done_resp", rp0, 1'b0);

    // misaligned write, read presented in ERR1 and accepted in ERR2
    adr(T_NSEQ, 1'b1, 10'h002, 3'd2);
    cyc();
    hwdata = 32'hBAD0BAD0;
    chk1("mis_e1_ready", ro0, 1'b0);
    chk1("mis_e1_resp", rp0, 1'b1);
    adr(T_NSEQ, 1'b0, 10'h000, 3'd2);
    cyc();
    chk1("mis_e2_ready", ro0, 1'b1);
    chk1("mis_e2_resp", rp0, 1'b1);
    cyc();
    idle();
    chk1("err2_acc_resp", rp0, 1'b0);
    chk32("mis_nowrite", rd0, 32'h0);

    // oversize write must not touch memory
    adr(T_NSEQ, 1'b1, 10'h008, 3'd3);
    cyc();
    idle();
    hwdata = 32'hFFFFFFFF;
    chk1("big_e1_resp", rp0, 1'b1);
    cyc();
    cyc();
    adr(T_NSEQ, 1'b0, 10'h008, 3'd2);
    cyc();
    idle();
    chk32("big_nowrite", rd0, 32'h0);
    cyc();

    // INCR4 write burst with a BUSY between beats 2 and 3
    adr(T_NSEQ, 1'b1, 10'h020, 3'd2);
    cyc();
    hwdata = 32'hA0A0A0A0;
    adr(T_SEQ, 1'b1, 10'h024, 3'd2);
    cyc();
    hwdata = 32'hB1B1B1B1;
    adr(T_BUSY, 1'b1, 10'h028, 3'd2);
    cyc();
    hwdata = 32'hEEEEEEEE;
    chk1("busy_ready", ro0, 1'b1);
    chk1("busy_okay", rp0, 1'b0);
    adr(T_SEQ, 1'b1, 10'h028, 3'd2);
    cyc();
    hwdata = 32'hC2C2C2C2;
    adr(T_SEQ, 1'b1, 10'h02C, 3'd2);
    cyc();
    hwdata = 32'hD3D3D3D3;
    idle();
    cyc();
    adr(T_NSEQ, 1'b0, 10'h020, 3'd2);
    cyc();
    adr(T_SEQ, 1'b0, 10'h024, 3'd2);
    chk32("burst0", rd0, 32'hA0A0A0A0);
    cyc();
    adr(T_SEQ, 1'b0, 10'h028, 3'd2);
    chk32("burst1", rd0, 32'hB1B1B1B1);
    cyc();
    adr(T_SEQ, 1'b0, 10'h02C, 3'd2);
    chk32("burst2", rd0, 32'hC2C2C2C2);
    cyc();
    idle();
    chk32("burst3", rd0, 32'hD3D3D3D3);
    cyc();

    // HREADY low in address phase: not accepted
    tgt = 1'b1;
    hold_lo = 1'b1;
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    chk1("hready_lo", ro3, 1'b1);
    hold_lo = 1'b0;

    // three wait states on write then read
    adr(T_NSEQ, 1'b1, 10'h004, 3'd2);
    cyc();
    idle();
    hwdata = 32'h0BADCAFE;
    for (int i = 0; i < 3; i++) begin
      chk1("ws_wr_low", ro3, 1'b0);
      cyc();
    end
    chk1("ws_wr_high", ro3, 1'b1);
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk1("ws_rd_low", ro3, 1'b0);
      cyc();
    end
    chk1("ws_rd_high", ro3, 1'b1);
    chk1("ws_rd_okay", rp3, 1'b0);
    chk32("ws_rd_data", rd3, 32'h0BADCAFE);
    cyc();

    // reset in the middle of a wait
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    idle();
    chk1("mid_wait_low", ro3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_ready", ro3, 1'b1);
    chk1("arst_resp", rp3, 1'b0);
    chk32("arst_rdata", rd3, 32'h0);
    chk32("arst_rdata0", rd0, 32'h0);
    cyc();
    rst = 1'b0;
    tgt = 1'b0;
    adr(T_NSEQ, 1'b0, 10'h004, 3'd2);
    cyc();
    adr(T_NSEQ, 1'b0, 10'h010, 3'd2);
    chk32("arst_mem04", rd0, 32'h0);
    cyc();
    adr(T_NSEQ, 1'b0, 10'h02C, 3'd2);
    chk32("arst_mem10", rd0, 32'h0);
    cyc();
    idle();
    chk32("arst_mem2c", rd0, 32'h0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
